// File: rtl/hamming_rx_decoder_pkg.sv
// Shared widths, parity encodings and the decoded-result record for the Hamming(7,4) receiver.
package hamming_rx_decoder_pkg;

   localparam int unsigned CW_W   = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SYN_W  = 3;
   localparam int unsigned CNT_W  = 16;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // One decoded word as held in the output stage.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SYN_W-1:0]  syndrome;
      logic              corrected;
   } dec_t;

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) syndrome and single-bit correction.
// codeword[k-1] is position k; parity at 1,2,4, data d0..d3 at 3,5,6,7.
module hamming74_correct
   import hamming_rx_decoder_pkg::*;
(
   input  logic [CW_W-1:0]   codeword,
   input  logic              parity_type,
   output logic [DATA_W-1:0] data,
   output logic [SYN_W-1:0]  syndrome,
   output logic              corrected
);

   logic [CW_W-1:0] flip_mask;
   logic [CW_W-1:0] fixed;

   // Syndrome, flip the named position, then pull out the data bits.
   always_comb begin
      syndrome    = '0;
      flip_mask   = '0;
      fixed       = codeword;
      // Odd parity is folded in so a clean odd word also yields syndrome 0.
      syndrome[0] = ^{codeword[0], codeword[2], codeword[4], codeword[6]} ^ parity_type;
      syndrome[1] = ^{codeword[1], codeword[2], codeword[5], codeword[6]} ^ parity_type;
      syndrome[2] = ^{codeword[3], codeword[4], codeword[5], codeword[6]} ^ parity_type;
      if (syndrome != '0) begin
         flip_mask = CW_W'(1) << (syndrome - SYN_W'(1));
      end
      fixed     = codeword ^ flip_mask;
      data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
      corrected = |syndrome;
   end

endmodule

// File: rtl/hamming_rx_decoder.sv
// Two-stage Hamming(7,4) receive decoder with valid/ready on both sides and word/error counters.
module hamming_rx_decoder
   import hamming_rx_decoder_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CW_W-1:0]   in_codeword,
   input  logic              in_parity_type,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SYN_W-1:0]  out_syndrome,
   output logic              out_corrected,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  word_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   logic            s1_valid_q;
   logic [CW_W-1:0] s1_cw_q;
   logic            s1_pt_q;
   logic            s2_valid_q;
   dec_t            s2_q;
   dec_t            dec;
   logic            s2_ready;
   logic            s1_advance;
   logic            in_xfer;
   logic            out_xfer;
   logic [CNT_W-1:0] word_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;

   hamming74_correct u_correct (
      .codeword    (s1_cw_q),
      .parity_type (s1_pt_q),
      .data        (dec.data),
      .syndrome    (dec.syndrome),
      .corrected   (dec.corrected)
   );

   // Handshake: S2 accepts when empty or draining; S1 moves on only into an accepting S2.
   always_comb begin
      s2_ready   = !s2_valid_q || out_ready;
      s1_advance = s1_valid_q && s2_ready;
      in_ready   = !rst && (!s1_valid_q || s1_advance);
      in_xfer    = in_valid && in_ready;
      out_xfer   = s2_valid_q && out_ready;
   end

   // Stage 1: raw codeword and its parity type.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_cw_q    <= '0;
         s1_pt_q    <= PAR_EVEN;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_cw_q <= in_codeword;
            s1_pt_q <= in_parity_type;
         end
      end
   end

   // Stage 2: decoded result, frozen while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else if (s2_ready) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_q <= dec;
         end
      end
   end

   // Counters: words accepted (wrapping) and corrected words emitted (saturating); clear wins.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if (in_xfer) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
         end
         if (out_xfer && s2_q.corrected && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   // Output drive straight from stage 2 registers.
   always_comb begin
      out_valid     = s2_valid_q;
      out_data      = s2_q.data;
      out_syndrome  = s2_q.syndrome;
      out_corrected = s2_q.corrected;
      word_cnt      = word_cnt_q;
      err_cnt       = err_cnt_q;
   end

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Directed bench for hamming_rx_decoder: inputs driven 1 ns after posedge, outputs sampled on negedge.
module tb_hamming_rx_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  in_codeword;
   logic        in_parity_type;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out_data;
   logic [2:0]  out_syndrome;
   logic        out_corrected;
   logic        out_valid;
   logic        out_ready;
   logic        clr_cnt;
   logic [15:0] word_cnt;
   logic [15:0] err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_words = 0;
   int exp_errs = 0;

   // Stream for the backpressure run, expected results worked out by hand.
   logic [6:0] bp_cw   [4] = '{7'b0101101, 7'b0111101, 7'b0100110, 7'b0100110};
   logic       bp_pt   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0] bp_data [4] = '{4'b0101, 4'b0101, 4'b0101, 4'b1101};
   logic [2:0] bp_syn  [4] = '{3'd0, 3'd5, 3'd0, 3'd7};
   logic       bp_corr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   hamming_rx_decoder dut (
      .clk            (clk),
      .rst            (rst),
      .in_codeword    (in_codeword),
      .in_parity_type (in_parity_type),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_syndrome   (out_syndrome),
      .out_corrected  (out_corrected),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .clr_cnt        (clr_cnt),
      .word_cnt       (word_cnt),
      .err_cnt        (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Send one word into an idle pipe and check latency, result and counters.
   task automatic run_word(input string tag, input logic [6:0] cw, input logic pt,
                           input logic [3:0] ed, input logic [2:0] es, input logic ec);
      @(posedge clk); #1;
      in_valid = 1'b1; in_codeword = cw; in_parity_type = pt; out_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "_in_ready"}, 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_words++;
      @(negedge clk);
      check_eq({tag, "_early_valid"}, 32'(out_valid), 0);
      check_eq({tag, "_word_cnt"}, 32'(word_cnt), exp_words);
      @(negedge clk);
      check_eq({tag, "_valid"}, 32'(out_valid), 1);
      check_eq({tag, "_data"}, 32'(out_data), 32'(ed));
      check_eq({tag, "_syn"}, 32'(out_syndrome), 32'(es));
      check_eq({tag, "_corr"}, 32'(out_corrected), 32'(ec));
      @(posedge clk);
      if (ec) exp_errs++;
      @(negedge clk);
      check_eq({tag, "_err_cnt"}, 32'(err_cnt), exp_errs);
      check_eq({tag, "_drained"}, 32'(out_valid), 0);
   endtask

   initial begin
      int   sent;
      int   rcv;
      int   n;
      logic acc;
      logic held;
      logic drop_seen;
      logic [3:0] h_data;
      logic [2:0] h_syn;
      logic       h_corr;

      rst = 1'b1; in_codeword = '0; in_parity_type = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; clr_cnt = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_in_ready", 32'(in_ready), 0);
      check_eq("rst_data", 32'(out_data), 0);
      check_eq("rst_syn", 32'(out_syndrome), 0);
      check_eq("rst_corr", 32'(out_corrected), 0);
      check_eq("rst_word_cnt", 32'(word_cnt), 0);
      check_eq("rst_err_cnt", 32'(err_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_in_ready", 32'(in_ready), 1);

      // Single words
      run_word("clean",   7'b0101101, 1'b0, 4'b0101, 3'd0, 1'b0);
      run_word("err_p5",  7'b0111101, 1'b0, 4'b0101, 3'd5, 1'b1);
      run_word("odd_ok",  7'b0100110, 1'b1, 4'b0101, 3'd0, 1'b0);
      run_word("odd_as_even", 7'b0100110, 1'b0, 4'b1101, 3'd7, 1'b1);
      run_word("err_p2",  7'b0101111, 1'b0, 4'b0101, 3'd2, 1'b1);
      run_word("err_p4",  7'b0100101, 1'b0, 4'b0101, 3'd4, 1'b1);

      // Backpressure: consumer stalls while four words stream in
      sent = 0; rcv = 0; acc = 1'b0; held = 1'b0; drop_seen = 1'b0;
      h_data = '0; h_syn = '0; h_corr = 1'b0;
      for (int c = 0; c < 40 && rcv < 4; c++) begin
         @(posedge clk);
         if (acc) sent++;
         #1;
         in_valid = (sent < 4);
         if (sent < 4) begin
            in_codeword = bp_cw[sent]; in_parity_type = bp_pt[sent];
         end
         out_ready = (c >= 5);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (in_valid && !in_ready && !drop_seen) begin
            drop_seen = 1'b1;
            check_eq("bp_accepts_before_drop", 32'(sent), 2);
         end
         if (held) begin
            check_eq("bp_hold_valid", 32'(out_valid), 1);
            check_eq("bp_hold_data", 32'(out_data), 32'(h_data));
            check_eq("bp_hold_syn", 32'(out_syndrome), 32'(h_syn));
            check_eq("bp_hold_corr", 32'(out_corrected), 32'(h_corr));
         end
         held = out_valid && !out_ready;
         h_data = out_data; h_syn = out_syndrome; h_corr = out_corrected;
         if (out_valid && out_ready) begin
            check_eq("bp_data", 32'(out_data), 32'(bp_data[rcv]));
            check_eq("bp_syn", 32'(out_syndrome), 32'(bp_syn[rcv]));
            check_eq("bp_corr", 32'(out_corrected), 32'(bp_corr[rcv]));
            rcv++;
         end
      end
      check_eq("bp_received", 32'(rcv), 4);
      check_eq("bp_drop_seen", 32'(drop_seen), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_no_dup", 32'(out_valid), 0);
      end
      exp_words += 4; exp_errs += 2;
      check_eq("bp_word_cnt", 32'(word_cnt), exp_words);
      check_eq("bp_err_cnt", 32'(err_cnt), exp_errs);

      // Counters: saturate err_cnt, wrap word_cnt, then clear against increments
      @(posedge clk); #1;
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      in_valid = 1'b1; in_codeword = 7'b0111101; in_parity_type = 1'b0; out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 70000 && n < 65538; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) n++;
         @(posedge clk); #1;
         if (n >= 65538) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check_eq("sat_accepted", 32'(n), 65538);
      repeat (4) @(negedge clk);
      check_eq("sat_err_cnt", 32'(err_cnt), 32'h0000_ffff);
      check_eq("wrap_word_cnt", 32'(word_cnt), 2);

      @(posedge clk); #1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr_cnt = 1'b1;
      @(negedge clk);
      check_eq("clr_pre_out_valid", 32'(out_valid), 1);
      check_eq("clr_pre_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      clr_cnt = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check_eq("clr_word_cnt", 32'(word_cnt), 0);
      check_eq("clr_err_cnt", 32'(err_cnt), 0);
      check_eq("clr_pipe_intact", 32'(out_valid), 1);
      repeat (3) @(negedge clk);
      check_eq("clr_after_drain_err", 32'(err_cnt), 2);
      check_eq("clr_after_drain_word", 32'(word_cnt), 0);

      // Reset with both stages full
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_codeword = 7'b0111101; in_parity_type = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("full_out_valid", 32'(out_valid), 1);
      check_eq("full_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_eq("midrst_out_valid", 32'(out_valid), 0);
      check_eq("midrst_word_cnt", 32'(word_cnt), 0);
      check_eq("midrst_err_cnt", 32'(err_cnt), 0);
      check_eq("midrst_in_ready", 32'(in_ready), 1);
      repeat (4) begin
         @(negedge clk);
         check_eq("midrst_no_stale", 32'(out_valid), 0);
      end
      check_eq("midrst_word_cnt_end", 32'(word_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
